// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: shares one DDR command port between a write requester and
// a read requester. Round-robin grant with a per-grant beat quota, feeding a
// single-entry registered command slot with a ready/hold handshake.
// Optional build macro: DDR_ARB_STATS_EN adds saturating beat/stall counters.
`timescale 1ns/1ps

module ddr_port_arbiter #(
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 64,
  parameter int QUOTA_BEATS    = 32,
  parameter int FIRST_GRANT_RD = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DDR_init_done,
  input  logic              DDR_cal_success,
  input  logic              DDR_calib_fail,
  input  logic              DDR_ready,
  input  logic              wr_req_in,
  input  logic [ADDR_W-1:0] wr_addr_in,
  input  logic [DATA_W-1:0] wr_data_in,
  output logic              wr_ack,
  input  logic              rd_req_in,
  input  logic [ADDR_W-1:0] rd_addr_in,
  output logic              rd_ack,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_req,
  output logic              rd_req,
  output logic              burtsbegin,
  output logic              grant_wr,
  output logic              grant_rd,
  output logic              arb_error
`ifdef DDR_ARB_STATS_EN
  ,
  output logic [31:0]       wr_beat_cnt,
  output logic [31:0]       rd_beat_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int CNT_W = $clog2(QUOTA_BEATS + 1);
  localparam logic [CNT_W-1:0] QUOTA = CNT_W'(QUOTA_BEATS);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WR,
    S_RD,
    S_FAULT
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] beat_cnt;
  logic             last_rd;     // 1 when the read port was the most recent grant
  logic             slot_full;
  logic             slot_free;
  logic             quota_hit;
  logic             wr_pend;
  logic             rd_pend;

  assign slot_full = wr_req | rd_req;
  assign slot_free = ~slot_full | DDR_ready;
  assign quota_hit = (beat_cnt == QUOTA);
  // A command is still pending if it is in the slot and not being taken now.
  assign wr_pend   = wr_req & ~DDR_ready;
  assign rd_pend   = rd_req & ~DDR_ready;

  // Acks are suppressed in the cycle a calibration failure arrives, because
  // the slot is flushed on entry to FAULT and an accepted beat would be lost.
  assign wr_ack = grant_wr & wr_req_in & slot_free & ~quota_hit & ~DDR_calib_fail;
  assign rd_ack = grant_rd & rd_req_in & slot_free & ~quota_hit & ~DDR_calib_fail;

  // Next-state decision: init gating, round-robin tie break, quota yield.
  always_comb begin
    state_next = state;
    case (state)
      S_INIT: begin
        if (DDR_init_done & DDR_cal_success) state_next = S_IDLE;
      end
      S_IDLE: begin
        if (wr_req_in & rd_req_in) state_next = last_rd ? S_WR : S_RD;
        else if (wr_req_in)        state_next = S_WR;
        else if (rd_req_in)        state_next = S_RD;
      end
      S_WR: begin
        if (rd_req_in & (quota_hit | (~wr_req_in & ~wr_pend)))
          state_next = S_RD;
        else if (~wr_req_in & ~rd_req_in & ~slot_full)
          state_next = S_IDLE;
      end
      S_RD: begin
        if (wr_req_in & (quota_hit | (~rd_req_in & ~rd_pend)))
          state_next = S_WR;
        else if (~wr_req_in & ~rd_req_in & ~slot_full)
          state_next = S_IDLE;
      end
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_INIT;
    endcase
    if (DDR_calib_fail) state_next = S_FAULT;
  end

  // Arbiter FSM with registered grant decodes, quota counter and error latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      grant_wr  <= 1'b0;
      grant_rd  <= 1'b0;
      arb_error <= 1'b0;
      beat_cnt  <= '0;
      last_rd   <= (FIRST_GRANT_RD == 0);
    end else begin
      state    <= state_next;
      grant_wr <= (state_next == S_WR);
      grant_rd <= (state_next == S_RD);
      if (state_next == S_FAULT) arb_error <= 1'b1;
      if (state_next != state)      beat_cnt <= '0;
      else if (wr_ack | rd_ack)     beat_cnt <= beat_cnt + CNT_W'(1);
      else if (quota_hit)           beat_cnt <= '0;  // nobody else waiting: renew quota
      if (state_next == S_WR && state != S_WR) last_rd <= 1'b0;
      if (state_next == S_RD && state != S_RD) last_rd <= 1'b1;
    end
  end

  // Single-entry command slot: load on ack, hold while stalled, clear on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr       <= '0;
      wr_data    <= '0;
      wr_req     <= 1'b0;
      rd_req     <= 1'b0;
      burtsbegin <= 1'b0;
    end else if (state_next == S_FAULT) begin
      wr_req     <= 1'b0;
      rd_req     <= 1'b0;
      burtsbegin <= 1'b0;
    end else if (wr_ack | rd_ack) begin
      addr       <= wr_ack ? wr_addr_in : rd_addr_in;
      if (wr_ack) wr_data <= wr_data_in;
      wr_req     <= wr_ack;
      rd_req     <= rd_ack;
      burtsbegin <= 1'b1;
    end else if (DDR_ready) begin
      wr_req     <= 1'b0;
      rd_req     <= 1'b0;
      burtsbegin <= 1'b0;
    end
  end

`ifdef DDR_ARB_STATS_EN
  // Saturating counters of accepted commands and backpressure stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_beat_cnt <= '0;
      rd_beat_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (wr_req & DDR_ready & ~(&wr_beat_cnt)) wr_beat_cnt <= wr_beat_cnt + 32'd1;
      if (rd_req & DDR_ready & ~(&rd_beat_cnt)) rd_beat_cnt <= rd_beat_cnt + 32'd1;
      if (slot_full & ~DDR_ready & ~(&stall_cnt)) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Testbench for ddr_port_arbiter (QUOTA_BEATS=4, read favoured first).
`timescale 1ns/1ps

module tb_ddr_port_arbiter;
  localparam int AW = 24;
  localparam int DW = 64;
  localparam int QB = 4;

  typedef struct packed {
    logic          is_rd;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_done, cal_success, calib_fail, ddr_ready;
  logic          wr_req_in, rd_req_in;
  logic [AW-1:0] wr_addr_in, rd_addr_in;
  logic [DW-1:0] wr_data_in;
  logic          wr_ack, rd_ack;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic          wr_req, rd_req, burtsbegin, grant_wr, grant_rd, arb_error;
`ifdef DDR_ARB_STATS_EN
  logic [31:0]   wr_beat_cnt, rd_beat_cnt, stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ddr_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .QUOTA_BEATS(QB), .FIRST_GRANT_RD(1)
  ) dut (
    .clk(clk), .rst(rst),
    .DDR_init_done(init_done), .DDR_cal_success(cal_success),
    .DDR_calib_fail(calib_fail), .DDR_ready(ddr_ready),
    .wr_req_in(wr_req_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
    .wr_ack(wr_ack),
    .rd_req_in(rd_req_in), .rd_addr_in(rd_addr_in), .rd_ack(rd_ack),
    .addr(addr), .wr_data(wr_data), .wr_req(wr_req), .rd_req(rd_req),
    .burtsbegin(burtsbegin), .grant_wr(grant_wr), .grant_rd(grant_rd),
    .arb_error(arb_error)
`ifdef DDR_ARB_STATS_EN
    , .wr_beat_cnt(wr_beat_cnt), .rd_beat_cnt(rd_beat_cnt), .stall_cnt(stall_cnt)
`endif
  );

  // One clock step; registered outputs are settled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, then complete init/calibration and settle in IDLE.
  task automatic bring_up();
    rst = 1'b1; init_done = 1'b0; cal_success = 1'b0; calib_fail = 1'b0;
    ddr_ready = 1'b1; wr_req_in = 1'b0; rd_req_in = 1'b0;
    wr_addr_in = '0; rd_addr_in = '0; wr_data_in = '0;
    repeat (2) tick();
    rst = 1'b0; init_done = 1'b1; cal_success = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; init_done = 1'b0; cal_success = 1'b0; calib_fail = 1'b0;
    ddr_ready = 1'b1; wr_req_in = 1'b1; rd_req_in = 1'b1;
    wr_addr_in = '1; rd_addr_in = '1; wr_data_in = '1;
    repeat (2) tick();
    checks++;
    if ({wr_req, rd_req, burtsbegin, grant_wr, grant_rd, arb_error} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000000", {wr_req, rd_req, burtsbegin, grant_wr, grant_rd, arb_error});
    end
    checks++;
    if (addr !== '0 || wr_data !== '0) begin
      failures++;
      $display("FAIL reset_cmd got addr=%0h data=%0h exp=0/0", addr, wr_data);
    end
    checks++;
    if (wr_ack !== 1'b0 || rd_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_ack got wr_ack=%b rd_ack=%b exp=0/0", wr_ack, rd_ack);
    end
    $display("test_reset done");
  endtask

  task automatic test_init_gating();
    int n;
    rst = 1'b1; init_done = 1'b0; cal_success = 1'b0; calib_fail = 1'b0;
    ddr_ready = 1'b1; wr_req_in = 1'b0; rd_req_in = 1'b0;
    repeat (2) tick();
    rst = 1'b0; wr_req_in = 1'b1; wr_addr_in = 24'h123; wr_data_in = 64'h55;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (wr_ack !== 1'b0 || grant_wr !== 1'b0) begin
        failures++;
        $display("FAIL init_no_ack cyc=%0d got wr_ack=%b grant_wr=%b exp=0/0", i, wr_ack, grant_wr);
      end
      tick();
      #1;
    end
    init_done = 1'b1; cal_success = 1'b1;
    #1;
    n = 0;
    while (wr_ack !== 1'b1 && n < 4) begin
      tick();
      #1;
      n++;
    end
    checks++;
    if (wr_ack !== 1'b1 || n > 2) begin
      failures++;
      $display("FAIL init_first_ack got cycles=%0d ack=%b exp<=2 ack=1", n, wr_ack);
    end
    tick();
    wr_req_in = 1'b0;
    repeat (3) tick();
    $display("test_init_gating done cycles=%0d", n);
  endtask

  task automatic test_write_stream();
    logic [DW-1:0] dat [10];
    logic [AW-1:0] issued [$];
    int            beat;
    bit            got;
    bring_up();
    for (int i = 0; i < 10; i++) dat[i] = {$urandom, $urandom};
    beat = 0;
    wr_req_in = 1'b1; wr_addr_in = '0; wr_data_in = dat[0];
    #1;
    for (int c = 0; c < 60 && issued.size() < 10; c++) begin
      got = (wr_ack === 1'b1);
      checks++;
      if (rd_ack !== 1'b0) begin
        failures++;
        $display("FAIL stream_rd_ack got=%b exp=0", rd_ack);
      end
      tick();
      if (wr_req === 1'b1) issued.push_back(addr);
      if (got) begin
        checks++;
        if (wr_req !== 1'b1 || addr !== AW'(beat) || wr_data !== dat[beat]) begin
          failures++;
          $display("FAIL stream_latency beat=%0d got req=%b addr=%0h data=%0h exp req=1 addr=%0h data=%0h",
                   beat, wr_req, addr, wr_data, beat, dat[beat]);
        end
        beat++;
        if (beat < 10) begin
          wr_addr_in = AW'(beat);
          wr_data_in = dat[beat];
        end else begin
          wr_req_in = 1'b0;
        end
      end
      #1;
    end
    wr_req_in = 1'b0;
    checks++;
    if (issued.size() != 10) begin
      failures++;
      $display("FAIL stream_count got=%0d exp=10", issued.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (issued[i] !== AW'(i)) begin
          failures++;
          $display("FAIL stream_order idx=%0d got=%0h exp=%0h", i, issued[i], i);
        end
      end
    end
    repeat (3) tick();
    $display("test_write_stream done beats=%0d", issued.size());
  endtask

  task automatic test_contention();
    bit ack_kind [$];
    int ack_cyc [$];
    bit iss_kind [$];
    bit got_w, got_r;
    bring_up();
    wr_req_in = 1'b1; rd_req_in = 1'b1; wr_addr_in = 24'h100; rd_addr_in = 24'h200;
    #1;
    for (int c = 0; c < 40 && ack_kind.size() < 12; c++) begin
      got_w = (wr_ack === 1'b1);
      got_r = (rd_ack === 1'b1);
      checks++;
      if (got_w && got_r) begin
        failures++;
        $display("FAIL contention_both_ack cyc=%0d", c);
      end
      if (got_r) begin ack_kind.push_back(1'b1); ack_cyc.push_back(c); end
      else if (got_w) begin ack_kind.push_back(1'b0); ack_cyc.push_back(c); end
      tick();
      if (rd_req === 1'b1) iss_kind.push_back(1'b1);
      else if (wr_req === 1'b1) iss_kind.push_back(1'b0);
      if (got_w) wr_addr_in = wr_addr_in + 1'b1;
      if (got_r) rd_addr_in = rd_addr_in + 1'b1;
      #1;
    end
    wr_req_in = 1'b0; rd_req_in = 1'b0;
    checks++;
    if (ack_kind.size() != 12 || iss_kind.size() < 12) begin
      failures++;
      $display("FAIL contention_count got acks=%0d issues=%0d exp=12/12", ack_kind.size(), iss_kind.size());
    end else begin
      for (int k = 0; k < 12; k++) begin
        checks++;
        if (ack_kind[k] !== (((k / QB) % 2) == 0) || iss_kind[k] !== (((k / QB) % 2) == 0)) begin
          failures++;
          $display("FAIL contention_order idx=%0d got ack_rd=%b iss_rd=%b exp_rd=%b",
                   k, ack_kind[k], iss_kind[k], ((k / QB) % 2) == 0);
        end
        if (k > 0) begin
          checks++;
          if (ack_cyc[k] - ack_cyc[k-1] > 2) begin
            failures++;
            $display("FAIL contention_gap idx=%0d got gap=%0d exp<=2", k, ack_cyc[k] - ack_cyc[k-1]);
          end
        end
      end
    end
    repeat (3) tick();
    $display("test_contention done acks=%0d", ack_kind.size());
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    int            n;
    bring_up();
    a0 = AW'($urandom); a1 = AW'($urandom); d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom};
    ddr_ready = 1'b0; wr_req_in = 1'b1; wr_addr_in = a0; wr_data_in = d0;
    #1;
    n = 0;
    while (wr_ack !== 1'b1 && n < 5) begin
      tick();
      #1;
      n++;
    end
    checks++;
    if (wr_ack !== 1'b1) begin
      failures++;
      $display("FAIL bp_first_ack got=%b exp=1", wr_ack);
    end
    tick();
    wr_addr_in = a1; wr_data_in = d1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (wr_ack !== 1'b0 || wr_req !== 1'b1 || addr !== a0 || wr_data !== d0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got ack=%b req=%b addr=%0h data=%0h exp ack=0 req=1 addr=%0h data=%0h",
                 i, wr_ack, wr_req, addr, wr_data, a0, d0);
      end
      tick();
      #1;
    end
    ddr_ready = 1'b1;
    #1;
    checks++;
    if (wr_ack !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ack got=%b exp=1", wr_ack);
    end
    tick();
    checks++;
    if (wr_req !== 1'b1 || addr !== a1 || wr_data !== d1) begin
      failures++;
      $display("FAIL bp_next_cmd got req=%b addr=%0h data=%0h exp req=1 addr=%0h data=%0h",
               wr_req, addr, wr_data, a1, d1);
    end
    wr_req_in = 1'b0;
    repeat (3) tick();
    $display("test_backpressure done");
  endtask

  task automatic test_calib_fail();
    bit got;
    bring_up();
    wr_req_in = 1'b1; wr_addr_in = 24'h40; wr_data_in = 64'hABCD;
    #1;
    for (int c = 0; c < 6; c++) begin
      got = (wr_ack === 1'b1);
      tick();
      if (got) wr_addr_in = wr_addr_in + 1'b1;
      #1;
    end
    calib_fail = 1'b1;
    #1;
    tick();
    checks++;
    if (arb_error !== 1'b1 || wr_req !== 1'b0 || rd_req !== 1'b0 || grant_wr !== 1'b0 || grant_rd !== 1'b0) begin
      failures++;
      $display("FAIL calib_entry got err=%b wr=%b rd=%b gw=%b gr=%b exp 1/0/0/0/0",
               arb_error, wr_req, rd_req, grant_wr, grant_rd);
    end
    rd_req_in = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 2) calib_fail = 1'b0;
      #1;
      checks++;
      if (wr_ack !== 1'b0 || rd_ack !== 1'b0 || wr_req !== 1'b0 || rd_req !== 1'b0 || arb_error !== 1'b1) begin
        failures++;
        $display("FAIL calib_persist cyc=%0d got ack=%b%b cmd=%b%b err=%b exp ack=00 cmd=00 err=1",
                 c, wr_ack, rd_ack, wr_req, rd_req, arb_error);
      end
      tick();
    end
    wr_req_in = 1'b0; rd_req_in = 1'b0;
    $display("test_calib_fail done");
  endtask

  task automatic test_reset_mid_burst();
    int n;
    bring_up();
    ddr_ready = 1'b0; rd_req_in = 1'b1; rd_addr_in = AW'($urandom);
    #1;
    n = 0;
    while (rd_ack !== 1'b1 && n < 5) begin
      tick();
      #1;
      n++;
    end
    tick();
    checks++;
    if (rd_req !== 1'b1) begin
      failures++;
      $display("FAIL rmb_pending got rd_req=%b exp=1", rd_req);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (rd_req !== 1'b0 || grant_rd !== 1'b0 || grant_wr !== 1'b0 || burtsbegin !== 1'b0 || addr !== '0) begin
      failures++;
      $display("FAIL rmb_cleared got rd=%b gr=%b gw=%b bb=%b addr=%0h exp 0/0/0/0/0",
               rd_req, grant_rd, grant_wr, burtsbegin, addr);
    end
    rst = 1'b0; init_done = 1'b0; cal_success = 1'b0; ddr_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (rd_ack !== 1'b0 || grant_rd !== 1'b0) begin
        failures++;
        $display("FAIL rmb_init_hold cyc=%0d got ack=%b grant=%b exp=0/0", c, rd_ack, grant_rd);
      end
      tick();
    end
    rd_req_in = 1'b0;
    $display("test_reset_mid_burst done");
  endtask

  // Random traffic: requesters hold each beat until acked; a scoreboard of
  // acked beats is matched against commands the DDR side accepts, and each
  // waiting port may see at most QB acks of the other port before its own.
  task automatic test_random();
    beat_t exp_q [$];
    beat_t wr_beat, rd_beat, last_acked, e;
    bit    wr_busy, rd_busy, acked_prev, hung;
    int    wr_wait, rd_wait, wr_cyc, rd_cyc, n_acc;
    bring_up();
    wr_busy = 0; rd_busy = 0; acked_prev = 0; hung = 0;
    wr_wait = 0; rd_wait = 0; wr_cyc = 0; rd_cyc = 0; n_acc = 0;
    wr_beat = '0; rd_beat = '0; last_acked = '0;
    for (int c = 0; c < 2000 && !hung; c++) begin
      checks++;
      if ((grant_wr & grant_rd) !== 1'b0 || burtsbegin !== (wr_req | rd_req)) begin
        failures++;
        $display("FAIL rnd_outputs cyc=%0d got gw=%b gr=%b bb=%b wr=%b rd=%b", c, grant_wr, grant_rd, burtsbegin, wr_req, rd_req);
      end
      if (acked_prev) begin
        checks++;
        if (rd_req !== last_acked.is_rd || wr_req !== !last_acked.is_rd || addr !== last_acked.a ||
            (!last_acked.is_rd && wr_data !== last_acked.d)) begin
          failures++;
          $display("FAIL rnd_latency cyc=%0d got rd=%b wr=%b addr=%0h exp rd=%b addr=%0h",
                   c, rd_req, wr_req, addr, last_acked.is_rd, last_acked.a);
        end
      end
      if (!wr_busy && $urandom_range(0, 99) < 60) begin
        wr_busy = 1; wr_beat.is_rd = 1'b0; wr_beat.a = AW'($urandom); wr_beat.d = {$urandom, $urandom};
        wr_wait = 0; wr_cyc = 0;
      end
      if (!rd_busy && $urandom_range(0, 99) < 60) begin
        rd_busy = 1; rd_beat.is_rd = 1'b1; rd_beat.a = AW'($urandom); rd_beat.d = '0;
        rd_wait = 0; rd_cyc = 0;
      end
      ddr_ready = ($urandom_range(0, 99) < 70);
      wr_req_in = wr_busy; wr_addr_in = wr_beat.a; wr_data_in = wr_beat.d;
      rd_req_in = rd_busy; rd_addr_in = rd_beat.a;
      #1;
      if ((wr_req | rd_req) === 1'b1 && ddr_ready) begin
        checks++;
        n_acc++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rnd_spurious cyc=%0d got addr=%0h exp=none", c, addr);
        end else begin
          e = exp_q.pop_front();
          if (rd_req !== e.is_rd || addr !== e.a || (!e.is_rd && wr_data !== e.d)) begin
            failures++;
            $display("FAIL rnd_scoreboard cyc=%0d got rd=%b addr=%0h data=%0h exp rd=%b addr=%0h data=%0h",
                     c, rd_req, addr, wr_data, e.is_rd, e.a, e.d);
          end
        end
      end
      checks++;
      if ((wr_ack === 1'b1 && rd_ack === 1'b1) ||
          (wr_ack === 1'b1 && !(wr_busy && grant_wr === 1'b1)) ||
          (rd_ack === 1'b1 && !(rd_busy && grant_rd === 1'b1))) begin
        failures++;
        $display("FAIL rnd_ack_rules cyc=%0d got wa=%b ra=%b gw=%b gr=%b", c, wr_ack, rd_ack, grant_wr, grant_rd);
      end
      acked_prev = 0;
      if (wr_ack === 1'b1) begin
        exp_q.push_back(wr_beat); last_acked = wr_beat; acked_prev = 1; wr_busy = 0;
      end else if (rd_ack === 1'b1) begin
        exp_q.push_back(rd_beat); last_acked = rd_beat; acked_prev = 1; rd_busy = 0;
      end
      if (wr_busy && rd_ack === 1'b1) wr_wait++;
      if (rd_busy && wr_ack === 1'b1) rd_wait++;
      if (wr_busy) wr_cyc++;
      if (rd_busy) rd_cyc++;
      checks++;
      if (wr_wait > QB || rd_wait > QB) begin
        failures++;
        $display("FAIL rnd_fairness cyc=%0d got wr_wait=%0d rd_wait=%0d exp<=%0d", c, wr_wait, rd_wait, QB);
      end
      checks++;
      if (wr_cyc > 300 || rd_cyc > 300 || exp_q.size() > 1) begin
        failures++;
        hung = 1;
        $display("FAIL rnd_progress cyc=%0d got wr_cyc=%0d rd_cyc=%0d inflight=%0d exp<=300/<=300/<=1",
                 c, wr_cyc, rd_cyc, exp_q.size());
      end
      tick();
    end
    wr_req_in = 1'b0; rd_req_in = 1'b0; ddr_ready = 1'b1;
    repeat (3) tick();
    $display("test_random done accepted=%0d", n_acc);
  endtask

  initial begin
    test_reset();
    test_init_gating();
    test_write_stream();
    test_contention();
    test_backpressure();
    test_random();
    test_calib_fail();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
